// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: raster timing and TMDS period sequencing for HDMI/DVI encoders
module hdmi_period_scheduler #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    parameter int DVI_MODE  = 0
) (
    input  logic        pixclk,
    input  logic        rst,
    input  logic        enable,
    output logic        busy,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        hsync,
    output logic        vsync,
    output logic [1:0]  mode,
    output logic [3:0]  ctl,
    output logic        pix_req,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    if (H_FRONT + H_SYNC + H_BACK < 22) begin : g_hblank_chk
        $fatal(1, "horizontal blanking too short for control, preamble and guard band");
    end
    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_chk
        $fatal(1, "raster totals exceed 12-bit counters");
    end
    localparam logic [11:0] HT1  = 12'(H_TOTAL - 1);
    localparam logic [11:0] VT1  = 12'(V_TOTAL - 1);
    localparam logic [11:0] HA   = 12'(H_ACTIVE);
    localparam logic [11:0] VA   = 12'(V_ACTIVE);
    localparam logic [11:0] VA1  = 12'(V_ACTIVE - 1);
    localparam logic [11:0] HS0  = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS1  = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] VS0  = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] VS1  = 12'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [11:0] PRE0 = 12'(H_TOTAL - 10);
    localparam logic [11:0] PRE1 = 12'(H_TOTAL - 3);
    localparam logic [11:0] GRD0 = 12'(H_TOTAL - 2);
    localparam logic        HP   = HSYNC_POL != 0;
    localparam logic        VP   = VSYNC_POL != 0;
    localparam logic        DVI  = DVI_MODE != 0;
    localparam logic [1:0]  M_CTRL = 2'd0, M_PRE = 2'd1, M_GRD = 2'd2, M_VID = 2'd3;

    typedef enum logic {IDLE, RUN} state_t;
    state_t st, nst;
    logic [11:0] nx, ny, ax, ay;
    logic run, line_ok, nhs, nvs;
    logic [1:0] nmode;

    // state and raster position register
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            x  <= '0;
            y  <= '0;
        end else begin
            st <= nst;
            x  <= nx;
            y  <= ny;
        end
    end

    // next state/position, plus the period and syncs belonging to that position
    always_comb begin
        nst = st;
        nx  = x;
        ny  = y;
        if (st == IDLE) begin
            if (enable) begin
                nst = RUN;
                nx  = '0;
                ny  = VA;
            end
        end else if (x == HT1 && y == VA1 && !enable) begin
            nst = IDLE;
            nx  = '0;
            ny  = '0;
        end else begin
            nx = x == HT1 ? '0 : x + 12'd1;
            ny = x == HT1 ? (y == VT1 ? '0 : y + 12'd1) : y;
        end
        ax      = nx == HT1 ? '0 : nx + 12'd1;
        ay      = nx == HT1 ? (ny == VT1 ? '0 : ny + 12'd1) : ny;
        run     = nst == RUN;
        line_ok = !DVI && (ny == VT1 || ny < VA1);
        nmode   = !run ? M_CTRL :
                  (nx < HA && ny < VA) ? M_VID :
                  (line_ok && nx >= PRE0 && nx <= PRE1) ? M_PRE :
                  (line_ok && nx >= GRD0) ? M_GRD : M_CTRL;
        nhs     = run && nx >= HS0 && nx < HS1;
        nvs     = run && ny >= VS0 && ny < VS1;
    end

    // registered outputs aligned with the registered position
    always_ff @(posedge pixclk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            hsync       <= ~HP;
            vsync       <= ~VP;
            mode        <= M_CTRL;
            ctl         <= 4'b0000;
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            busy        <= run;
            hsync       <= nhs ? HP : ~HP;
            vsync       <= nvs ? VP : ~VP;
            mode        <= nmode;
            ctl         <= nmode == M_PRE ? 4'b0001 : 4'b0000;
            pix_req     <= run && ax < HA && ay < VA;
            frame_start <= run && nx == '0 && ny == '0;
        end
    end
endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Sequences the per-pixel HDMI period type for the three TMDS channel encoders: control, video preamble, video guard band, active video.
- Generates the raster position, sync levels and the pixel-fetch request that drive the pattern generator and encoders.
- Runs in the pixel clock domain and starts and stops only at clean frame boundaries under a run enable.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FRONT, 16, horizontal front porch, in pixels
H_SYNC, 96, hsync width, in pixels
H_BACK, 48, horizontal back porch, in pixels
V_ACTIVE, 480, active lines per frame
V_FRONT, 10, vertical front porch, in lines
V_SYNC, 2, vsync height, in lines
V_BACK, 33, vertical back porch, in lines
HSYNC_POL, 0, 1 = hsync active-high, 0 = active-low
VSYNC_POL, 0, 1 = vsync active-high, 0 = active-low
DVI_MODE, 0, 1 = no preamble or guard band (only CTRL and VIDEO periods)

Ports:
pixclk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
enable  in  1  run request
busy  out  1  scheduler in RUN state
x  out  12  current column
y  out  12  current row
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
mode  out  2  period type: 0 = CTRL, 1 = PREAMBLE, 2 = GUARD, 3 = VIDEO
ctl  out  4  {CTL3,CTL2,CTL1,CTL0} for channels 1/2
pix_req  out  1  next cycle is VIDEO; pixel source must present data then
frame_start  out  1  one-cycle pulse at (0,0)

Behaviour:
- H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- Elaboration check: H_FRONT+H_SYNC+H_BACK >= 22 (12 control + 8 preamble + 2 guard). Failing the check is a fatal elaboration error.
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE; x = 0, y = 0; mode = CTRL; ctl = 0.
  - busy, pix_req and frame_start = 0.
  - hsync and vsync are driven to their inactive levels (hsync = ~HSYNC_POL, vsync = ~VSYNC_POL).
- All outputs are registered. Within a cycle they describe the same position (x,y), with no skew between them.
- State IDLE:
  - Outputs are held at their reset values.
  - enable = 1 at a clock edge: the next cycle is RUN with x = 0 and y = V_ACTIVE (first blanking line), so a preamble always precedes the first active line.
- State RUN, raster counters:
  - x increments by 1 each cycle and wraps from H_TOTAL-1 to 0.
  - y increments when x wraps, and itself wraps from V_TOTAL-1 to 0.
- Stop rule:
  - enable is sampled only at the cycle where x = H_TOTAL-1 and y = V_ACTIVE-1.
  - If enable = 0 there, the next cycle is IDLE (counters at 0).
  - enable changes at any other time have no effect.
  - The frame in flight always completes, and a pending preamble is never abandoned.
- Sync levels:
  - hsync is asserted while H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync is asserted while V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC, for all x on those lines.
- Period selection, in priority order:
  - VIDEO: x < H_ACTIVE and y < V_ACTIVE.
  - PREAMBLE: DVI_MODE = 0, the next line is active (next y < V_ACTIVE, including y = V_TOTAL-1 wrapping to 0), and H_TOTAL-10 <= x <= H_TOTAL-3.
  - GUARD: same line condition, with x = H_TOTAL-2 or H_TOTAL-1.
  - CTRL: otherwise.
- ctl is 4'b0001 during PREAMBLE and 4'b0000 otherwise.
- pix_req is 1 exactly when the next cycle's mode will be VIDEO; it is always 0 if the next cycle is IDLE.
- frame_start is 1 exactly in the cycle where x = 0, y = 0 and the state is RUN.
- busy is 1 exactly in RUN cycles.
- Counter arithmetic uses 12 bits. Parameters must keep H_TOTAL and V_TOTAL <= 4096.

Test Plan:
Small parameter set used throughout: H_ACTIVE = 8, H_FRONT = 4, H_SYNC = 4, H_BACK = 14 (H_TOTAL = 30); V_ACTIVE = 4, V_FRONT = 1, V_SYNC = 1, V_BACK = 1 (V_TOTAL = 7).
1. Reset then enable = 1 -> next cycle busy = 1, x = 0, y = 4. The first PREAMBLE appears at y = 6, x = 20..27 with ctl = 0001, followed by GUARD at x = 28..29. frame_start pulses at (0,0), then VIDEO at x = 0..7.
2. Steady RUN, line y = 2 -> mode = VIDEO at x = 0..7. hsync is asserted at x = 12..15 (low, since HSYNC_POL = 0). PREAMBLE at x = 20..27 and GUARD at x = 28..29 because line 3 is active. pix_req is high at (29,2) and at x = 0..6, and low at x = 7.
3. Line y = 3 -> no PREAMBLE or GUARD on that line (line 4 is blanking). vsync is asserted on all of y = 5 only.
4. enable dropped at y = 1 -> the frame continues unchanged. At (29,3) the next cycle is IDLE with busy = 0, x = 0 and y = 0; pix_req stays 0. Re-asserting enable restarts at y = 4.
5. Assert rst at (5,2) during VIDEO -> outputs go to reset values immediately, without waiting for a clock edge. After release, the block stays IDLE until enable is seen.
6. DVI_MODE = 1 -> mode is never 1 or 2 and ctl stays 0; VIDEO and sync timing are identical to scenario 2.
